// File: rtl/bbus_pkg.sv
// bbus_pkg: shared types and constants for the B-bus initiator and its bench.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bbus_pkg;

  // Bus-cycle phases of the initiator.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } bbus_state_e;

  // Responder register map as seen from the B-bus.
  localparam logic [7:0] BBUS_ADDR_STATUS   = 8'hFE;
  localparam logic [7:0] BBUS_ADDR_FIFO     = 8'hFF;
  localparam logic [7:0] BBUS_ADDR_ROM_BASE = 8'h84;

  // Bit positions inside the status byte read from BBUS_ADDR_STATUS.
  localparam int BBUS_STAT_RXF_BIT = 1;
  localparam int BBUS_STAT_TXE_BIT = 0;

  // A phase lasting n clocks loads n-1: the counter's zero cycle is the last one.
  function automatic logic [7:0] bbus_phase_load(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/bbus_phase_counter.sv
// bbus_phase_counter: loadable 8-bit down-counter, terminal count when zero.
// Latency: load_val_i visible on count the cycle after load_i; tc_o is combinational from the count.
// Backpressure: none; stops at zero until reloaded.
module bbus_phase_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       tc_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == 8'd0);

endmodule

// File: rtl/bbus_master.sv
// bbus_master: B-bus initiator turning valid/ready commands into PA/PARD_n/PAWR_n cycles.
// Latency: strobe falls SETUP_CYC clocks after accept; rsp_valid SETUP_CYC+STROBE_CYC+1 clocks after accept.
// Backpressure: cmd_ready only while idle; BBUS_MASTER_BURST_EN adds cmd_len/cmd_inc multi-beat commands.
module bbus_master
  import bbus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned STROBE_CYC = 8,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
`ifdef BBUS_MASTER_BURST_EN
  input  logic [7:0] cmd_len,
  input  logic       cmd_inc,
`endif
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] PA,
  output logic       PARD_n,
  output logic       PAWR_n,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  localparam logic [7:0] SETUP_LD  = bbus_phase_load(SETUP_CYC);
  localparam logic [7:0] STROBE_LD = bbus_phase_load(STROBE_CYC);
  localparam logic [7:0] HOLD_LD   = bbus_phase_load(HOLD_CYC);

  bbus_state_e state_q;
  logic [7:0]  pa_q;
  logic        pard_n_q;
  logic        pawr_n_q;
  logic [7:0]  dout_q;
  logic        doe_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic        write_q;
  logic        accept;
  logic        more_beats;
  logic        cnt_load;
  logic [7:0]  cnt_val;
  logic        cnt_tc;

`ifdef BBUS_MASTER_BURST_EN
  logic [7:0]  beats_q;
  logic        inc_q;
  assign more_beats = (beats_q != 8'd0);
`else
  assign more_beats = 1'b0;
`endif

  // Ready only decodes state and reset so a command is never taken during reset.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Reload the phase counter on every state entry with that phase's length.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 8'h00;
    case (state_q)
      S_IDLE:   if (accept)               begin cnt_load = 1'b1; cnt_val = SETUP_LD;  end
      S_SETUP:  if (cnt_tc)               begin cnt_load = 1'b1; cnt_val = STROBE_LD; end
      S_STROBE: if (cnt_tc)               begin cnt_load = 1'b1; cnt_val = HOLD_LD;   end
      S_HOLD:   if (cnt_tc && more_beats) begin cnt_load = 1'b1; cnt_val = SETUP_LD;  end
      default:  ;
    endcase
  end

  bbus_phase_counter u_phase (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  // Bus-cycle FSM; every bus pin is driven straight from a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pa_q        <= 8'h00;
      pard_n_q    <= 1'b1;
      pawr_n_q    <= 1'b1;
      dout_q      <= 8'h00;
      doe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      write_q     <= 1'b0;
`ifdef BBUS_MASTER_BURST_EN
      beats_q     <= 8'd0;
      inc_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_SETUP;
            write_q <= cmd_write;
            pa_q    <= cmd_addr;
            doe_q   <= cmd_write;
            if (cmd_write) begin
              dout_q <= cmd_wdata;
            end
`ifdef BBUS_MASTER_BURST_EN
            beats_q <= cmd_len;
            inc_q   <= cmd_inc;
`endif
          end
        end
        S_SETUP: begin
          if (cnt_tc) begin
            state_q <= S_STROBE;
            if (write_q) begin
              pawr_n_q <= 1'b0;
            end else begin
              pard_n_q <= 1'b0;
            end
          end
        end
        S_STROBE: begin
          // Read data is captured on the same edge the strobe rises.
          if (cnt_tc) begin
            state_q     <= S_HOLD;
            pard_n_q    <= 1'b1;
            pawr_n_q    <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= write_q ? 8'h00 : data_in;
          end
        end
        S_HOLD: begin
          if (cnt_tc) begin
            if (more_beats) begin
              state_q <= S_SETUP;
`ifdef BBUS_MASTER_BURST_EN
              beats_q <= beats_q - 8'd1;
              pa_q    <= pa_q + {7'b0, inc_q};
`endif
            end else begin
              state_q <= S_IDLE;
              doe_q   <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PA        = pa_q;
  assign PARD_n    = pard_n_q;
  assign PAWR_n    = pawr_n_q;
  assign data_out  = dout_q;
  assign data_oe   = doe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/bbus_master.md
# bbus_master

B-bus initiator that generates SNES-style peripheral bus cycles (PA, PARD_n, PAWR_n, data) from a simple valid/ready command interface. It is the initiating end of the B-bus protocol our SNES-side responder implements: status reads at $FE, FIFO data at $FF, boot ROM at $84–$FF. It sits in FPGA test and bring-up rigs, where it stands in for the SNES CPU and drives the responder CPLD.

## Interface
- SETUP_CYC, 3: clocks PA is stable before a strobe falls (≥1, ≤255)
- STROBE_CYC, 8: clocks PARD_n/PAWR_n stay low (≥1, ≤255)
- HOLD_CYC, 2: clocks PA/data are held after a strobe rises (≥1, ≤255)

- clk  in  1  system clock (40 MHz)
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write cycle, 0 = read cycle
- cmd_addr  in  8  B-bus address
- cmd_wdata  in  8  write data
- cmd_len  in  8  beat count minus 1 (only with BBUS_MASTER_BURST_EN)
- cmd_inc  in  1  increment address per beat (only with BBUS_MASTER_BURST_EN)
- rsp_valid  out  1  one-cycle pulse per completed beat
- rsp_data  out  8  read data; 0x00 for write beats
- PA  out  8  B-bus address
- PARD_n  out  1  read strobe, active low
- PAWR_n  out  1  write strobe, active low
- data_out  out  8  bus write data
- data_oe  out  1  tristate enable for data_out
- data_in  in  8  bus read data

## Operation
- States: IDLE, SETUP, STROBE, HOLD. One 8-bit phase counter, reloaded on every state entry.
- IDLE: cmd_ready=1. On accept, the block latches cmd_write, cmd_addr, cmd_wdata (and len/inc) and moves to SETUP.
- SETUP: PA=latched address. For writes, data_oe=1 and data_out=latched wdata. After SETUP_CYC clocks, moves to STROBE.
- STROBE: PARD_n=0 (read) or PAWR_n=0 (write), never both. For reads, data_in is registered on the edge that leaves STROBE.
- HOLD: strobes high; PA and, for writes, data_oe/data_out are unchanged. rsp_valid=1 in the first HOLD cycle. After HOLD_CYC clocks, the block goes to IDLE, or to SETUP for the next burst beat.
- cmd_ready=0 in every state except IDLE. The latched command is immune to input changes while the block is busy.
- Reset values: PA=0x00, PARD_n=1, PAWR_n=1, data_oe=0, data_out=0x00, rsp_valid=0, rsp_data=0x00, cmd_ready=0, state=IDLE.
- Reset mid-cycle takes effect on the next edge: strobes deassert, data_oe drops, no rsp_valid, any burst is discarded.
- Address increment wraps 0xFF→0x00.

## Timing
- Accept at edge 0. SETUP occupies cycles 1..SETUP_CYC. STROBE occupies the next STROBE_CYC cycles. HOLD occupies the next HOLD_CYC cycles.
- Defaults: SETUP 1–3, strobe 4–11, HOLD 12–13, rsp_valid in cycle 12, cmd_ready high again in cycle 14.
- Beat period is SETUP_CYC+STROBE_CYC+HOLD_CYC. A single command costs one extra IDLE cycle; burst beats have no IDLE gap.
- All outputs are registered except cmd_ready, which decodes state and rst only.

## Configuration
- BBUS_MASTER_BURST_EN defined:
  - cmd_len/cmd_inc ports exist.
  - One command runs cmd_len+1 beats, keeping the same address (FIFO port $FF) or incrementing it (ROM window) per cmd_inc.
  - Write bursts repeat the same wdata.
- Undefined: ports absent, every command is exactly one beat.

## Structure
- Package bbus_pkg holds:
  - state enum
  - address constants BBUS_ADDR_STATUS=8'hFE, BBUS_ADDR_FIFO=8'hFF, BBUS_ADDR_ROM_BASE=8'h84
  - status bit positions (bit1 RXF, bit0 TXE)
- Sub-module bbus_phase_counter: loadable 8-bit down-counter with a terminal-count flag, instanced once.

## Test plan
- Read $FE, responder drives 0x02 → PA=0xFE in cycles 1–13, PARD_n low exactly cycles 4–11, PAWR_n stays 1, rsp_valid in cycle 12 with rsp_data=0x02.
- Write $FF 0xA5 → data_oe=1 with data_out=0xA5 in cycles 1–13, PAWR_n low cycles 4–11, rsp_data=0x00.
- cmd_valid held with two commands → second accept at edge 14, PA changes in cycle 15. Toggling cmd_wdata mid-cycle leaves data_out unchanged.
- rst asserted in cycle 6 of a read → next cycle PARD_n=1, data_oe=0, PA=0x00, no rsp_valid, cmd_ready=1 the cycle after rst drops.
- (BURST_EN) read, cmd_addr=0x84, cmd_len=3, cmd_inc=1 → PA 84,85,86,87, four rsp_valid pulses 13 cycles apart, cmd_ready low until the burst ends.
- (BURST_EN) cmd_addr=0xFF, cmd_inc=1, cmd_len=1 → PA 0xFF then 0x00.
